// File: rtl/tlk_tx_framer_pkg.sv
// Shared constants for the TLK transmit framer and the
// receive-side frame checker.
package tlk_tx_framer_pkg;

   typedef enum logic [2:0] {
      OFF,
      TRAIN,
      GAP,
      HDR,
      PAY,
      TRL,
      ERR
   } state_t;

   localparam logic [3:0]  TRL_TAG        = 4'hE;
   localparam logic [15:0] ERR_WORD       = 16'hFFFF;
   localparam logic [15:0] HEADER_DEFAULT = 16'hBC5A;

   function automatic logic [15:0] trailer_word(input logic [11:0] count);
      return {TRL_TAG, count};
   endfunction

endpackage

// File: rtl/tlk_tx_framer.sv
// TLK transmit link controller: trains the far-end receiver with idle,
// then frames upstream payload as HEADER, payload, TRAILER.
module tlk_tx_framer
   import tlk_tx_framer_pkg::*;
#(
   parameter int unsigned TRAIN_CYCLES = 1023,
   parameter logic [15:0] HEADER       = HEADER_DEFAULT,
   parameter int unsigned MIN_GAP      = 4,
   parameter int unsigned MAX_WORDS    = 4095
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        LIVE,
   input  logic [15:0] din,
   input  logic        din_valid,
   input  logic        din_last,
   output logic        din_ready,
   output logic [15:0] txd,
   output logic        tx_en,
   output logic        tx_er,
   output logic        link_ready,
   output logic        underflow
);

   localparam int TW = $clog2(TRAIN_CYCLES + 1);
   localparam int GW = $clog2(MIN_GAP + 1);
   localparam logic [TW-1:0] TRAIN_LAST = TW'(TRAIN_CYCLES - 1);
   localparam logic [GW-1:0] GAP_LAST   = GW'(MIN_GAP - 1);
   localparam logic [11:0]   WORDS_LAST = 12'(MAX_WORDS - 1);

   state_t        state, state_n;
   logic [TW-1:0] train_cnt, train_cnt_n;
   logic [GW-1:0] gap_cnt, gap_cnt_n;
   logic [11:0]   count, count_n;
   logic          link_ready_n, underflow_n;
   logic [15:0]   txd_n;
   logic          tx_en_n, tx_er_n;

   assign din_ready = (state == PAY);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= OFF;
         train_cnt  <= '0;
         gap_cnt    <= '0;
         count      <= '0;
         link_ready <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         state      <= state_n;
         train_cnt  <= train_cnt_n;
         gap_cnt    <= gap_cnt_n;
         count      <= count_n;
         link_ready <= link_ready_n;
         underflow  <= underflow_n;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         txd   <= '0;
         tx_en <= 1'b0;
         tx_er <= 1'b0;
      end else begin
         txd   <= txd_n;
         tx_en <= tx_en_n;
         tx_er <= tx_er_n;
      end
   end

   always_comb begin
      state_n      = state;
      train_cnt_n  = '0;
      gap_cnt_n    = '0;
      count_n      = count;
      link_ready_n = link_ready;
      underflow_n  = underflow;
      txd_n        = '0;
      tx_en_n      = 1'b0;
      tx_er_n      = 1'b0;
      unique case (state)
         OFF: begin
            if (LIVE) state_n = TRAIN;
         end
         TRAIN: begin
            if (train_cnt == TRAIN_LAST) begin
               state_n      = GAP;
               link_ready_n = 1'b1;
            end else begin
               train_cnt_n = train_cnt + TW'(1);
            end
         end
         GAP: begin
            // counter saturates so a late source still sees a full gap
            if (gap_cnt == GAP_LAST) begin
               gap_cnt_n = gap_cnt;
               if (din_valid) state_n = HDR;
            end else begin
               gap_cnt_n = gap_cnt + GW'(1);
            end
         end
         HDR: begin
            txd_n   = HEADER;
            tx_en_n = 1'b1;
            state_n = PAY;
         end
         PAY: begin
            if (din_valid) begin
               txd_n   = din;
               tx_en_n = 1'b1;
               count_n = count + 12'd1;
               if (din_last || count == WORDS_LAST) state_n = TRL;
            end else begin
               state_n = ERR;
            end
         end
         TRL: begin
            txd_n   = trailer_word(count);
            tx_en_n = 1'b1;
            count_n = '0;
            state_n = GAP;
         end
         ERR: begin
            txd_n       = ERR_WORD;
            tx_en_n     = 1'b1;
            tx_er_n     = 1'b1;
            underflow_n = 1'b1;
            count_n     = '0;
            state_n     = GAP;
         end
         default: state_n = OFF;
      endcase
      // link down drops any frame in progress and restarts training
      if (!LIVE) begin
         state_n      = OFF;
         train_cnt_n  = '0;
         gap_cnt_n    = '0;
         count_n      = '0;
         link_ready_n = 1'b0;
         txd_n        = '0;
         tx_en_n      = 1'b0;
         tx_er_n      = 1'b0;
      end
   end

endmodule

// File: tb/tb_tlk_tx_framer.sv
// Self-checking bench for tlk_tx_framer: scoreboard of expected wire
// words, checked by a monitor as the framer transmits them.
module tb_tlk_tx_framer;

   localparam int unsigned TRAIN = 1023;
   localparam int unsigned GAPN  = 4;
   localparam int unsigned MAXW  = 8;
   localparam logic [15:0] HDRW  = 16'hBC5A;

   typedef struct packed {
      logic [15:0] txd;
      logic        er;
      logic        contig;
      logic        hdr;
      logic        fin;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        LIVE = 1'b0;
   logic [15:0] din = '0;
   logic        din_valid = 1'b0;
   logic        din_last = 1'b0;
   logic        din_ready;
   logic [15:0] txd;
   logic        tx_en;
   logic        tx_er;
   logic        link_ready;
   logic        underflow;

   int          checks = 0;
   int          errors = 0;
   exp_t        sb[$];
   logic [15:0] src[$];
   int          cyc = 0;
   int          last_cyc = 0;
   int          idle_run = 0;
   bit          seen_end = 0;
   exp_t        e;

   tlk_tx_framer #(
      .TRAIN_CYCLES(TRAIN),
      .HEADER(HDRW),
      .MIN_GAP(GAPN),
      .MAX_WORDS(MAXW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .LIVE(LIVE),
      .din(din),
      .din_valid(din_valid),
      .din_last(din_last),
      .din_ready(din_ready),
      .txd(txd),
      .tx_en(tx_en),
      .tx_er(tx_er),
      .link_ready(link_ready),
      .underflow(underflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (reset) begin
         seen_end = 0;
         idle_run = 0;
      end else if (tx_en) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL stray_word: got txd=%h tx_er=%b, required no output", txd, tx_er);
         end else begin
            e = sb.pop_front();
            if (txd !== e.txd || tx_er !== e.er) begin
               errors++;
               $display("FAIL wire_word: got txd=%h tx_er=%b, required txd=%h tx_er=%b",
                        txd, tx_er, e.txd, e.er);
            end
            if (e.contig) begin
               checks++;
               if (cyc != last_cyc + 1) begin
                  errors++;
                  $display("FAIL contiguous: word %h at cycle %0d, required cycle %0d",
                           e.txd, cyc, last_cyc + 1);
               end
            end
            if (e.hdr && seen_end) begin
               checks++;
               if (idle_run < int'(GAPN)) begin
                  errors++;
                  $display("FAIL min_gap: got %0d idle cycles, required >= %0d", idle_run, GAPN);
               end
            end
            if (e.hdr) seen_end = 0;
            if (e.fin) seen_end = 1;
         end
         idle_run = 0;
         last_cyc = cyc;
      end else begin
         idle_run++;
         if (tx_er !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL idle_er: got tx_er=%b while idle, required 0", tx_er);
         end
      end
   end

   task automatic push(input logic [15:0] w, input logic er, input logic contig,
                       input logic hdr, input logic fin);
      exp_t x;
      x.txd = w; x.er = er; x.contig = contig; x.hdr = hdr; x.fin = fin;
      sb.push_back(x);
   endtask

   task automatic drive_src(input int n, input bit last_end);
      bit acc;
      for (int i = 0; i < n; i++) begin
         din       = src[i];
         din_valid = 1'b1;
         din_last  = last_end && (i == n - 1);
         acc = 0;
         for (int c = 0; c < 100 && !acc; c++) begin
            @(negedge clk);
            acc = din_ready;
            @(posedge clk);
            #1;
         end
         if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: word %h never accepted, required within 100 cycles", src[i]);
         end
      end
      din_valid = 1'b0;
      din_last  = 1'b0;
   endtask

   task automatic drain(output int left);
      for (int c = 0; c < 40 && sb.size() != 0; c++) begin
         @(negedge clk);
         #1;
      end
      repeat (6) @(negedge clk);
      #1;
      left = sb.size();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (txd !== 16'h0) begin errors++; $display("FAIL reset_txd: got %h, required 0000", txd); end
      checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en: got %b, required 0", tx_en); end
      checks++; if (tx_er !== 1'b0) begin errors++; $display("FAIL reset_tx_er: got %b, required 0", tx_er); end
      checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL reset_din_ready: got %b, required 0", din_ready); end
      checks++; if (link_ready !== 1'b0) begin errors++; $display("FAIL reset_link_ready: got %b, required 0", link_ready); end
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b, required 0", underflow); end
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      checks++;
      if (link_ready !== 1'b0 || tx_en !== 1'b0) begin
         errors++;
         $display("FAIL off_idle: got link_ready=%b tx_en=%b, required 0 0", link_ready, tx_en);
      end
   endtask

   task automatic test_training();
      int rise;
      int bad_en;
      LIVE = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      LIVE = 1'b1;
      rise = -1;
      bad_en = 0;
      for (int n = 1; n <= 2000 && rise < 0; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (tx_en !== 1'b0) bad_en++;
         if (link_ready === 1'b1) rise = n;
      end
      checks++;
      if (rise != int'(TRAIN) + 1) begin
         errors++;
         $display("FAIL train_len: link_ready at cycle %0d, required %0d", rise, TRAIN + 1);
      end
      checks++;
      if (bad_en != 0) begin
         errors++;
         $display("FAIL train_idle: tx_en high %0d cycles, required 0", bad_en);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_normal();
      int left;
      push(HDRW, 0, 0, 1, 0);
      push(16'h0001, 0, 1, 0, 0);
      push(16'h0002, 0, 1, 0, 0);
      push(16'h0003, 0, 1, 0, 0);
      push(16'hE003, 0, 1, 0, 1);
      src = '{16'h0001, 16'h0002, 16'h0003};
      drive_src(3, 1'b1);
      drain(left);
      checks++;
      if (left != 0) begin
         errors++;
         $display("FAIL normal_drain: %0d words outstanding, required 0", left);
      end
   endtask

   task automatic test_underflow();
      int left;
      checks++;
      if (underflow !== 1'b0) begin
         errors++;
         $display("FAIL underflow_pre: got %b, required 0", underflow);
      end
      push(HDRW, 0, 0, 1, 0);
      push(16'h0011, 0, 1, 0, 0);
      push(16'h0012, 0, 1, 0, 0);
      push(16'hFFFF, 1, 0, 0, 1);
      push(HDRW, 0, 0, 1, 0);
      push(16'h0021, 0, 1, 0, 0);
      push(16'h0022, 0, 1, 0, 0);
      push(16'hE002, 0, 1, 0, 1);
      src = '{16'h0011, 16'h0012};
      drive_src(2, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      src = '{16'h0021, 16'h0022};
      drive_src(2, 1'b1);
      drain(left);
      checks++;
      if (left != 0) begin
         errors++;
         $display("FAIL underflow_drain: %0d words outstanding, required 0", left);
      end
      checks++;
      if (underflow !== 1'b1) begin
         errors++;
         $display("FAIL underflow_flag: got %b, required 1", underflow);
      end
   endtask

   task automatic test_max_len();
      int left;
      push(HDRW, 0, 0, 1, 0);
      for (int i = 0; i < 8; i++) push(16'h0100 + 16'(i), 0, 1, 0, 0);
      push(16'hE008, 0, 1, 0, 1);
      push(HDRW, 0, 0, 1, 0);
      push(16'h0108, 0, 1, 0, 0);
      push(16'h0109, 0, 1, 0, 0);
      push(16'hE002, 0, 1, 0, 1);
      src = {};
      for (int i = 0; i < 10; i++) src.push_back(16'h0100 + 16'(i));
      drive_src(10, 1'b1);
      drain(left);
      checks++;
      if (left != 0) begin
         errors++;
         $display("FAIL maxlen_drain: %0d words outstanding, required 0", left);
      end
   endtask

   task automatic test_live_drop();
      int left;
      push(HDRW, 0, 0, 1, 0);
      push(16'h0031, 0, 1, 0, 0);
      push(16'h0032, 0, 1, 0, 0);
      src = '{16'h0031, 16'h0032};
      drive_src(2, 1'b0);
      LIVE = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (tx_en !== 1'b0) begin
         errors++;
         $display("FAIL drop_tx_en: got %b, required 0", tx_en);
      end
      checks++;
      if (link_ready !== 1'b0) begin
         errors++;
         $display("FAIL drop_link_ready: got %b, required 0", link_ready);
      end
      drain(left);
      checks++;
      if (left != 0) begin
         errors++;
         $display("FAIL drop_drain: %0d words outstanding, required 0", left);
      end
      test_training();
      test_normal();
   endtask

   task automatic test_async_reset();
      bit acc;
      push(HDRW, 0, 0, 1, 0);
      din = 16'h0051;
      din_valid = 1'b1;
      din_last = 1'b0;
      acc = 0;
      for (int c = 0; c < 50 && !acc; c++) begin
         @(negedge clk);
         acc = din_ready;
      end
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL arst_pay: din_ready never rose, required within 50 cycles");
      end
      @(posedge clk);
      #2;
      checks++;
      if (tx_en !== 1'b1 || txd !== 16'h0051) begin
         errors++;
         $display("FAIL arst_pre: got tx_en=%b txd=%h, required 1 0051", tx_en, txd);
      end
      #1;
      reset = 1'b1;
      #1;
      checks++; if (txd !== 16'h0) begin errors++; $display("FAIL arst_txd: got %h, required 0000", txd); end
      checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL arst_tx_en: got %b, required 0", tx_en); end
      checks++; if (tx_er !== 1'b0) begin errors++; $display("FAIL arst_tx_er: got %b, required 0", tx_er); end
      checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL arst_din_ready: got %b, required 0", din_ready); end
      checks++; if (link_ready !== 1'b0) begin errors++; $display("FAIL arst_link_ready: got %b, required 0", link_ready); end
      checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL arst_underflow: got %b, required 0", underflow); end
      din_valid = 1'b0;
      LIVE = 1'b0;
      sb.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish within 400000 time units");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_training();
      test_normal();
      test_underflow();
      test_max_len();
      test_live_drop();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
